// File: rtl/puertas_autotest.sv
// Self-test sequencer for the puertas gate block: drives the four input vectors,
// checks the seven gate outputs against the truth table and reports the results.
module puertas_autotest #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_bit1,
  output logic             o_bit2,
  input  logic             i_and,
  input  logic             i_nand,
  input  logic             i_or,
  input  logic             i_nor,
  input  logic             i_not,
  input  logic             i_xor,
  input  logic             i_xnor,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_count,
  output logic [6:0]       o_err_mask,
  output logic [1:0]       o_first_fail,
  output logic             o_first_fail_valid
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam bit         NO_SETTLE = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [3:0]       cnt;
  logic [6:0]       golden;
  logic [6:0]       observed;
  logic [6:0]       mismatch;
  logic [CNT_W-1:0] count_nxt;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 7; i++) s = s + {2'b00, v[i]};
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Bit order matches o_err_mask: [0]and .. [6]xnor
  always_comb begin
    golden   = {~(o_bit1 ^ o_bit2), o_bit1 ^ o_bit2, ~o_bit1, ~(o_bit1 | o_bit2),
                o_bit1 | o_bit2, ~(o_bit1 & o_bit2), o_bit1 & o_bit2};
    observed = {i_xnor, i_xor, i_not, i_nor, i_or, i_nand, i_and};
    mismatch = golden ^ observed;
    count_nxt = sat_add(o_err_count, popcount7(mismatch));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = NO_SETTLE ? CHECK : SETTLE;
      SETTLE:  if (cnt == 4'd1) state_nxt = CHECK;
      CHECK:   if (idx == 2'd3) state_nxt = DONE;
               else state_nxt = NO_SETTLE ? CHECK : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx                <= '0;
      cnt                <= '0;
      o_bit1             <= 1'b0;
      o_bit2             <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_pass             <= 1'b0;
      o_err_count        <= '0;
      o_err_mask         <= '0;
      o_first_fail       <= '0;
      o_first_fail_valid <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            idx                <= '0;
            cnt                <= SETTLE_LD;
            o_bit1             <= 1'b0;
            o_bit2             <= 1'b0;
            o_busy             <= 1'b1;
            o_pass             <= 1'b0;
            o_err_count        <= '0;
            o_err_mask         <= '0;
            o_first_fail       <= '0;
            o_first_fail_valid <= 1'b0;
          end
        end
        SETTLE: cnt <= cnt - 4'd1;
        CHECK: begin
          o_err_count <= count_nxt;
          o_err_mask  <= o_err_mask | mismatch;
          if ((|mismatch) && !o_first_fail_valid) begin
            o_first_fail       <= {o_bit1, o_bit2};
            o_first_fail_valid <= 1'b1;
          end
          if (idx != 2'd3) begin
            idx              <= idx + 2'd1;
            {o_bit1, o_bit2} <= idx + 2'd1;
            cnt              <= SETTLE_LD;
          end else begin
            o_done <= 1'b1;
            o_pass <= (count_nxt == '0);
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          o_bit1 <= 1'b0;
          o_bit2 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puertas_autotest.sv
// Directed bench for puertas_autotest: a default instance (SETTLE_CYCLES=1, CNT_W=5)
// and a fast instance (SETTLE_CYCLES=0, CNT_W=4), each fed by a behavioural gate model.
module tb_puertas_autotest;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       a_bit1, a_bit2, a_busy, a_done, a_pass, a_ffv;
  logic [4:0] a_cnt;
  logic [6:0] a_mask, a_gates;
  logic [1:0] a_ff;
  // Instance B: no settle cycles, 4-bit counter
  logic       b_bit1, b_bit2, b_busy, b_done, b_pass, b_ffv;
  logic [3:0] b_cnt;
  logic [6:0] b_mask, b_gates;
  logic [1:0] b_ff;

  // Returns {xnor,xor,not,nor,or,nand,and}; mode selects a faulty gate block.
  function automatic logic [6:0] gates(input int m, input logic a, input logic b);
    logic g_and, g_nand, g_or, g_nor, g_not, g_xor, g_xnor;
    g_and  = a & b;
    g_nand = ~(a & b);
    g_or   = a | b;
    g_nor  = ~(a | b);
    g_not  = ~a;
    g_xor  = a ^ b;
    g_xnor = ~(a ^ b);
    if (m == 1) g_xor = 1'b0;
    if (m == 2) g_not = ~b;
    if (m == 3) return ~{g_xnor, g_xor, g_not, g_nor, g_or, g_nand, g_and};
    return {g_xnor, g_xor, g_not, g_nor, g_or, g_nand, g_and};
  endfunction

  assign a_gates = gates(mode, a_bit1, a_bit2);
  assign b_gates = gates(mode, b_bit1, b_bit2);

  puertas_autotest dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_bit1(a_bit1), .o_bit2(a_bit2),
    .i_and(a_gates[0]), .i_nand(a_gates[1]), .i_or(a_gates[2]), .i_nor(a_gates[3]),
    .i_not(a_gates[4]), .i_xor(a_gates[5]), .i_xnor(a_gates[6]),
    .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_err_count(a_cnt),
    .o_err_mask(a_mask), .o_first_fail(a_ff), .o_first_fail_valid(a_ffv)
  );

  puertas_autotest #(.SETTLE_CYCLES(0), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_bit1(b_bit1), .o_bit2(b_bit2),
    .i_and(b_gates[0]), .i_nand(b_gates[1]), .i_or(b_gates[2]), .i_nor(b_gates[3]),
    .i_not(b_gates[4]), .i_xor(b_gates[5]), .i_xnor(b_gates[6]),
    .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_err_count(b_cnt),
    .o_err_mask(b_mask), .o_first_fail(b_ff), .o_first_fail_valid(b_ffv)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results of the last run
  int         a_done_edge, a_done_cnt, b_done_edge, b_done_cnt;
  logic [7:0] a_seq;

  // Start pulse at E0, optional second pulse sampled at E3; observes E0..E12.
  task automatic run(input int m, input bit repulse);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_e0", a_busy, 1);
    check("clear_e0", {a_pass, a_cnt, a_mask, a_ff, a_ffv}, 0);
    a_done_edge = -1; a_done_cnt = 0; b_done_edge = -1; b_done_cnt = 0; a_seq = '0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (a_done) begin
        if (a_done_edge < 0) a_done_edge = n;
        a_done_cnt++;
      end
      if (b_done) begin
        if (b_done_edge < 0) b_done_edge = n;
        b_done_cnt++;
      end
      if (n % 2 == 1 && n <= 7) a_seq = {a_seq[5:0], a_bit1, a_bit2};
      if (n == 8) check("busy_done", a_busy, 1);
      if (n == 9) check("busy_idle", {a_busy, a_bit1, a_bit2}, 0);
      if (repulse && n == 2) start = 1'b1;
      if (n == 3) start = 1'b0;
    end
    check("a_done_edge", a_done_edge, 8);
    check("a_done_cnt", a_done_cnt, 1);
    check("b_done_edge", b_done_edge, 4);
    check("b_done_cnt", b_done_cnt, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", {a_bit1, a_bit2, a_busy, a_done, a_pass, a_cnt, a_mask, a_ff, a_ffv}, 0);
    check("reset_b", {b_bit1, b_bit2, b_busy, b_done, b_pass, b_cnt, b_mask, b_ff, b_ffv}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct gate block
    run(0, 1'b0);
    check("t1_seq", a_seq, 8'b00_01_10_11);
    check("t1_a_res", {a_pass, a_cnt, a_mask, a_ffv}, {1'b1, 5'd0, 7'h00, 1'b0});
    check("t1_b_res", {b_pass, b_cnt, b_mask, b_ffv}, {1'b1, 4'd0, 7'h00, 1'b0});

    // xor stuck at 0
    run(1, 1'b0);
    check("t2_a_res", {a_pass, a_cnt, a_mask, a_ff, a_ffv}, {1'b0, 5'd2, 7'h20, 2'b01, 1'b1});
    check("t2_b_cnt", b_cnt, 2);

    // Second start clears the failure results; re-pulse at E3 ignored
    run(0, 1'b1);
    check("t5_a_res", {a_pass, a_cnt, a_mask, a_ffv}, {1'b1, 5'd0, 7'h00, 1'b0});
    check("t5_hold", a_pass, 1);

    // not wired to ~bit2
    run(2, 1'b0);
    check("t3_a_res", {a_pass, a_cnt, a_mask, a_ff, a_ffv}, {1'b0, 5'd2, 7'h10, 2'b01, 1'b1});

    // Every output inverted
    run(3, 1'b0);
    check("t4_a_res", {a_pass, a_cnt, a_mask, a_ff, a_ffv}, {1'b0, 5'd28, 7'h7F, 2'b00, 1'b1});
    check("t4_b_sat", {b_pass, b_cnt, b_mask}, {1'b0, 4'd15, 7'h7F});

    // Reset while vector 10 is settling (between E4 and E5 for instance A)
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_pre_vec", {a_bit1, a_bit2}, 2'b01);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_a", {a_bit1, a_bit2, a_busy, a_done, a_pass, a_cnt, a_mask, a_ff, a_ffv}, 0);
    a_done_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b1;
      a_done_cnt += int'(a_done);
    end
    check("t6_no_done", a_done_cnt, 0);
    check("t6_idle", {a_busy, a_bit1, a_bit2}, 0);
    run(0, 1'b0);
    check("t6_rerun", {a_pass, a_cnt, a_ffv}, {1'b1, 5'd0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
